vc_credit_tracker: RTL and testbench

Per-output-port credit tracker for the virtual channel router. Keeps one credit counter per downstream VC buffer. Each counter is decremented when a flit is sent on that VC and incremented when the downstream router returns a credit. Drives one credit-available bit per VC; the switch-stage 2-input AND gate combines each bit with that VC's flit-valid to form the send request.

---
 rtl/vc_credit_tracker.sv | 94 +++++++++
 tb/tb_vc_credit_tracker.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/vc_credit_tracker.sv
// Credit tracker for one output port: one saturating credit counter per
// downstream VC buffer, a credit-available decode and sticky error flags.
module vc_credit_tracker #(
  parameter int VC_W  = 2,
  parameter int DEPTH = 4,
  parameter int CNT_W = 3
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          send_valid,
  input  logic [VC_W-1:0]               send_vc,
  input  logic                          cred_valid,
  input  logic [VC_W-1:0]               cred_vc,
  input  logic                          err_clr,
  output logic [(2**VC_W)-1:0]          credit_avail,
  output logic [(2**VC_W)*CNT_W-1:0]    credit_count,
  output logic                          err_underflow,
  output logic                          err_overflow
);

  localparam int NUM_VC = 2 ** VC_W;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

  // Handshake: send_valid/cred_valid are single-cycle events with no ready.
  // A send is legal only when credit_avail[send_vc] was 1 in that same cycle;
  // a credit is legal only when the VC holds fewer than DEPTH credits.
  // Illegal events saturate the counter and raise the matching sticky flag.

  logic [CNT_W-1:0]  r_count [NUM_VC];
  logic [CNT_W-1:0]  w_count_nxt [NUM_VC];
  logic [NUM_VC-1:0] w_dec;
  logic [NUM_VC-1:0] w_inc;
  logic [NUM_VC-1:0] w_uf_evt;
  logic [NUM_VC-1:0] w_of_evt;
  logic              r_err_underflow;
  logic              r_err_overflow;
  logic              w_err_underflow_nxt;
  logic              w_err_overflow_nxt;

  always_comb begin
    for (int v = 0; v < NUM_VC; v++) begin
      w_dec[v]       = send_valid && (send_vc == VC_W'(v));
      w_inc[v]       = cred_valid && (cred_vc == VC_W'(v));
      w_count_nxt[v] = r_count[v];
      w_uf_evt[v]    = 1'b0;
      w_of_evt[v]    = 1'b0;
      // Simultaneous send and credit on one VC cancel, even at 0 or DEPTH.
      unique case ({w_dec[v], w_inc[v]})
        2'b10: begin
          if (r_count[v] == '0) w_uf_evt[v] = 1'b1;
          else                  w_count_nxt[v] = r_count[v] - 1'b1;
        end
        2'b01: begin
          if (r_count[v] == DEPTH_C) w_of_evt[v] = 1'b1;
          else                       w_count_nxt[v] = r_count[v] + 1'b1;
        end
        default: w_count_nxt[v] = r_count[v];
      endcase
    end
  end

  // A new error event outranks a clear arriving in the same cycle.
  always_comb begin
    w_err_underflow_nxt = r_err_underflow;
    w_err_overflow_nxt  = r_err_overflow;
    if (err_clr) begin
      w_err_underflow_nxt = 1'b0;
      w_err_overflow_nxt  = 1'b0;
    end
    if (|w_uf_evt) w_err_underflow_nxt = 1'b1;
    if (|w_of_evt) w_err_overflow_nxt  = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int v = 0; v < NUM_VC; v++) r_count[v] <= DEPTH_C;
      r_err_underflow <= 1'b0;
      r_err_overflow  <= 1'b0;
    end else begin
      for (int v = 0; v < NUM_VC; v++) r_count[v] <= w_count_nxt[v];
      r_err_underflow <= w_err_underflow_nxt;
      r_err_overflow  <= w_err_overflow_nxt;
    end
  end

  for (genvar g = 0; g < NUM_VC; g++) begin : g_out
    assign credit_count[g*CNT_W +: CNT_W] = r_count[g];
    assign credit_avail[g]                = |r_count[g];
  end

  assign err_underflow = r_err_underflow;
  assign err_overflow  = r_err_overflow;

endmodule

// File: tb/tb_vc_credit_tracker.sv
// Directed and random checks of vc_credit_tracker against an
// arithmetic model of the per-VC credit counts.
module tb_vc_credit_tracker;

  localparam int VC_W   = 2;
  localparam int DEPTH  = 4;
  localparam int CNT_W  = 3;
  localparam int NUM_VC = 2 ** VC_W;

  logic                       clk;
  logic                       rst;
  logic                       send_valid;
  logic [VC_W-1:0]            send_vc;
  logic                       cred_valid;
  logic [VC_W-1:0]            cred_vc;
  logic                       err_clr;
  logic [NUM_VC-1:0]          credit_avail;
  logic [NUM_VC*CNT_W-1:0]    credit_count;
  logic                       err_underflow;
  logic                       err_overflow;

  int n_checks = 0;
  int n_fail   = 0;

  // reference model
  int m_cnt [NUM_VC];
  bit m_uf;
  bit m_of;

  vc_credit_tracker #(.VC_W(VC_W), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk          (clk),
    .rst          (rst),
    .send_valid   (send_valid),
    .send_vc      (send_vc),
    .cred_valid   (cred_valid),
    .cred_vc      (cred_vc),
    .err_clr      (err_clr),
    .credit_avail (credit_avail),
    .credit_count (credit_count),
    .err_underflow(err_underflow),
    .err_overflow (err_overflow)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic model_reset();
    for (int v = 0; v < NUM_VC; v++) m_cnt[v] = DEPTH;
    m_uf = 1'b0;
    m_of = 1'b0;
  endtask

  task automatic model_edge(input bit sv, input int svc, input bit cv, input int cvc,
                            input bit clr);
    bit uf_evt;
    bit of_evt;
    uf_evt = 1'b0;
    of_evt = 1'b0;
    for (int v = 0; v < NUM_VC; v++) begin
      bit d;
      bit i;
      d = sv && (svc == v);
      i = cv && (cvc == v);
      if (d && !i) begin
        if (m_cnt[v] == 0) uf_evt = 1'b1;
        else m_cnt[v] = m_cnt[v] - 1;
      end else if (i && !d) begin
        if (m_cnt[v] == DEPTH) of_evt = 1'b1;
        else m_cnt[v] = m_cnt[v] + 1;
      end
    end
    if (clr) begin
      m_uf = 1'b0;
      m_of = 1'b0;
    end
    if (uf_evt) m_uf = 1'b1;
    if (of_evt) m_of = 1'b1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    logic [NUM_VC*CNT_W-1:0] exp_cnt;
    logic [NUM_VC-1:0]       exp_av;
    for (int v = 0; v < NUM_VC; v++) begin
      exp_cnt[v*CNT_W +: CNT_W] = CNT_W'(m_cnt[v]);
      exp_av[v]                 = (m_cnt[v] != 0);
    end
    check({tag, ".count"}, 32'(credit_count), 32'(exp_cnt));
    check({tag, ".avail"}, 32'(credit_avail), 32'(exp_av));
    check({tag, ".uf"},    32'(err_underflow), 32'(m_uf));
    check({tag, ".of"},    32'(err_overflow),  32'(m_of));
  endtask

  // driver: one clock cycle of stimulus, then model update and compare
  task automatic step(input string tag, input bit sv, input int svc, input bit cv,
                      input int cvc, input bit clr);
    send_valid = sv;
    send_vc    = VC_W'(svc);
    cred_valid = cv;
    cred_vc    = VC_W'(cvc);
    err_clr    = clr;
    @(posedge clk);
    #1;
    model_edge(sv, svc, cv, cvc, clr);
    send_valid = 1'b0;
    cred_valid = 1'b0;
    err_clr    = 1'b0;
    check_all(tag);
  endtask

  initial begin
    send_valid = 1'b0;
    send_vc    = '0;
    cred_valid = 1'b0;
    cred_vc    = '0;
    err_clr    = 1'b0;
    rst        = 1'b1;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_all("reset");
    rst = 1'b0;

    // drain VC2
    for (int k = 0; k < 4; k++) step("drain_vc2", 1, 2, 0, 0, 0);
    check("vc2_zero_avail", 32'(credit_avail[2]), 32'd0);

    // underflow, sticky, clear
    step("underflow", 1, 2, 0, 0, 0);
    check("uf_set", 32'(err_underflow), 32'd1);
    step("uf_sticky", 0, 0, 0, 0, 0);
    step("uf_clear", 0, 0, 0, 0, 1);

    // overflow on full VC1, then clear and event in the same cycle
    step("overflow", 0, 0, 1, 1, 0);
    check("of_set", 32'(err_overflow), 32'd1);
    step("of_clear", 0, 0, 0, 0, 1);
    step("of_clr_vs_evt", 0, 0, 1, 1, 1);
    step("of_clear2", 0, 0, 0, 0, 1);

    // VC1 to zero, then send and credit together
    for (int k = 0; k < 4; k++) step("drain_vc1", 1, 1, 0, 0, 0);
    step("cancel_at_zero", 1, 1, 1, 1, 0);
    check("cancel_no_uf", 32'(err_underflow), 32'd0);

    // asynchronous reset between edges
    @(posedge clk);
    #3;
    rst = 1'b1;
    model_reset();
    #1;
    check_all("async_reset");
    @(posedge clk);
    #1;
    rst = 1'b0;

    // count0=2, count3=1, then independent updates in one cycle
    for (int k = 0; k < 2; k++) step("setup_vc0", 1, 0, 0, 0, 0);
    for (int k = 0; k < 3; k++) step("setup_vc3", 1, 3, 0, 0, 0);
    step("two_vc", 1, 0, 1, 3, 0);
    check("two_vc_c0", 32'(credit_count[0 +: CNT_W]), 32'd1);
    check("two_vc_c3", 32'(credit_count[3*CNT_W +: CNT_W]), 32'd2);

    // random traffic with sends gated by available credit
    for (int n = 0; n < 400; n++) begin
      int  svc;
      int  cvc;
      bit  sv;
      bit  cv;
      svc = $urandom_range(NUM_VC - 1, 0);
      cvc = $urandom_range(NUM_VC - 1, 0);
      sv  = ($urandom_range(3, 0) != 0) && (m_cnt[svc] != 0);
      cv  = ($urandom_range(1, 0) != 0) && (m_cnt[cvc] != DEPTH);
      step("random", sv, svc, cv, cvc, 0);
    end
    check("random_no_uf", 32'(err_underflow), 32'd0);
    check("random_no_of", 32'(err_overflow), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
